// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters advanced by a pixel-rate enable,
// decoded sync/active/strobe outputs, and an optional aligned output delay pipeline.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned PIPE_DEPTH = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pixEn,
  output logic             hSync,
  output logic             vSync,
  output logic [CNT_W-1:0] hCounter,
  output logic [CNT_W-1:0] vCounter,
  output logic             vidOn,
  output logic             lineStart,
  output logic             frameStart
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

  if (H_SYNC == 0 || V_SYNC == 0) begin : g_err_sync
    $error("vga_timing_gen: sync width must be non-zero");
  end
  if (CNT_W == 0 || ((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0)
  begin : g_err_cnt_w
    $error("vga_timing_gen: CNT_W too small for H_TOTAL-1 / V_TOTAL-1");
  end
  if (PIPE_DEPTH > 4) begin : g_err_pipe
    $error("vga_timing_gen: PIPE_DEPTH must be 0..4");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             vid;
    logic             ls;
    logic             fs;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
  } tim_t;

  // Pipe reset image: syncs idle, strobes and active-video low, origin counters.
  localparam tim_t TIM_RST = '{
    hs:  ~HS_POL,
    vs:  ~VS_POL,
    vid: 1'b0,
    ls:  1'b0,
    fs:  1'b0,
    hc:  {CNT_W{1'b0}},
    vc:  {CNT_W{1'b0}}
  };

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixEn) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  logic [31:0] h_ext, v_ext;
  tim_t        dec;
  tim_t        out;

  assign h_ext = 32'(h_q);
  assign v_ext = 32'(v_q);

  always_comb begin
    dec     = TIM_RST;
    dec.vid = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
    dec.hs  = ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) ? HS_POL : ~HS_POL;
    dec.vs  = ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) ? VS_POL : ~VS_POL;
    dec.ls  = (h_q == '0);
    dec.fs  = (h_q == '0) && (v_q == '0);
    dec.hc  = h_q;
    dec.vc  = v_q;
  end

  if (PIPE_DEPTH == 0) begin : g_no_pipe
    assign out = dec;
  end else begin : g_pipe
    tim_t pipe_q [PIPE_DEPTH];

    // Every stage shares the pixel enable so all fields stay aligned in pixel ticks.
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
          pipe_q[i] <= TIM_RST;
        end
      end else if (pixEn) begin
        pipe_q[0] <= dec;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign out = pipe_q[PIPE_DEPTH-1];
  end

  assign hSync      = out.hs;
  assign vSync      = out.vs;
  assign vidOn      = out.vid;
  assign lineStart  = out.ls;
  assign frameStart = out.fs;
  assign hCounter   = out.hc;
  assign vCounter   = out.vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (default, small/medium rasters, piped and unpiped)
// share clock, reset and pixEn; expectations come from a tick-count arithmetic model.
module tb_vga_timing_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pixEn = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int t     = 0;  // enabled pixel ticks since last reset

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vid;
    logic        ls;
    logic        fs;
    logic [15:0] hc;
    logic [15:0] vc;
  } obs_t;

  logic       hs_a, vs_a, vid_a, ls_a, fs_a;
  logic [9:0] hc_a, vc_a;
  logic       hs_b, vs_b, vid_b, ls_b, fs_b;
  logic [4:0] hc_b, vc_b;
  logic       hs_c, vs_c, vid_c, ls_c, fs_c;
  logic [3:0] hc_c, vc_c;
  logic       hs_d, vs_d, vid_d, ls_d, fs_d;
  logic [3:0] hc_d, vc_d;

  vga_timing_gen u_def (
    .clock(clock), .reset(reset), .pixEn(pixEn), .hSync(hs_a), .vSync(vs_a),
    .hCounter(hc_a), .vCounter(vc_a), .vidOn(vid_a), .lineStart(ls_a), .frameStart(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2),
    .V_BP(2), .CNT_W(5), .PIPE_DEPTH(2)
  ) u_med (
    .clock(clock), .reset(reset), .pixEn(pixEn), .hSync(hs_b), .vSync(vs_b),
    .hCounter(hc_b), .vCounter(vc_b), .vidOn(vid_b), .lineStart(ls_b), .frameStart(fs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .PIPE_DEPTH(0)
  ) u_sm0 (
    .clock(clock), .reset(reset), .pixEn(pixEn), .hSync(hs_c), .vSync(vs_c),
    .hCounter(hc_c), .vCounter(vc_c), .vidOn(vid_c), .lineStart(ls_c), .frameStart(fs_c)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .PIPE_DEPTH(3)
  ) u_sm3 (
    .clock(clock), .reset(reset), .pixEn(pixEn), .hSync(hs_d), .vSync(vs_d),
    .hCounter(hc_d), .vCounter(vc_d), .vidOn(vid_d), .lineStart(ls_d), .frameStart(fs_d)
  );

  function automatic obs_t act_of(int k);
    obs_t o;
    case (k)
      0:       o = '{hs_a, vs_a, vid_a, ls_a, fs_a, 16'(hc_a), 16'(vc_a)};
      1:       o = '{hs_b, vs_b, vid_b, ls_b, fs_b, 16'(hc_b), 16'(vc_b)};
      2:       o = '{hs_c, vs_c, vid_c, ls_c, fs_c, 16'(hc_c), 16'(vc_c)};
      default: o = '{hs_d, vs_d, vid_d, ls_d, fs_d, 16'(hc_d), 16'(vc_d)};
    endcase
    return o;
  endfunction

  // Raster position is simply the delayed tick count folded by line and frame length.
  function automatic obs_t model(int k, int tick);
    int ha, hf, hw, hb, va, vf, vw, vb, d, n, h, v;
    bit hp, vp;
    obs_t o;
    case (k)
      0: begin
        ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
        hp = 1'b0; vp = 1'b0; d = 0;
      end
      1: begin
        ha = 16; hf = 2; hw = 4; hb = 2; va = 12; vf = 2; vw = 2; vb = 2;
        hp = 1'b0; vp = 1'b0; d = 2;
      end
      2: begin
        ha = 8; hf = 2; hw = 3; hb = 2; va = 4; vf = 1; vw = 1; vb = 1;
        hp = 1'b1; vp = 1'b1; d = 0;
      end
      default: begin
        ha = 8; hf = 2; hw = 3; hb = 2; va = 4; vf = 1; vw = 1; vb = 1;
        hp = 1'b1; vp = 1'b1; d = 3;
      end
    endcase
    if (tick < d) begin
      o = '{~hp, ~vp, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
      return o;
    end
    n     = tick - d;
    h     = n % (ha + hf + hw + hb);
    v     = (n / (ha + hf + hw + hb)) % (va + vf + vw + vb);
    o.hs  = (h >= ha + hf && h < ha + hf + hw) ? hp : ~hp;
    o.vs  = (v >= va + vf && v < va + vf + vw) ? vp : ~vp;
    o.vid = (h < ha) && (v < va);
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    o.hc  = 16'(h);
    o.vc  = 16'(v);
    return o;
  endfunction

  task automatic tick(input logic r, input logic e);
    reset = r;
    pixEn = e;
    @(posedge clock);
    if (r) t = 0;
    else if (e) t++;
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (act_of(k) !== model(k, t)) begin
        bad++;
        $display("FAIL reset_state inst=%0d got=%h want=%h", k, act_of(k), model(k, t));
      end
    end
    total++;
    if ({hs_a, vs_a, vid_a, ls_a, fs_a} !== 5'b11111) begin
      bad++;
      $display("FAIL reset_unpiped got=%b want=11111", {hs_a, vs_a, vid_a, ls_a, fs_a});
    end
  endtask

  task automatic test_free_run();
    int hs_low, vid_hi;
    hs_low = 0;
    vid_hi = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 2400; i++) begin
      tick(1'b0, 1'b1);
      if (i < 800) begin
        hs_low += (hs_a == 1'b0) ? 1 : 0;
        vid_hi += (vid_a == 1'b1) ? 1 : 0;
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (act_of(k) !== model(k, t)) begin
          bad++;
          $display("FAIL free_run inst=%0d t=%0d got=%h want=%h", k, t, act_of(k), model(k, t));
        end
      end
    end
    total++;
    if (hs_low != 96) begin
      bad++;
      $display("FAIL hsync_low_per_line got=%0d want=96", hs_low);
    end
    total++;
    if (vid_hi != 640) begin
      bad++;
      $display("FAIL vidon_per_line got=%0d want=640", vid_hi);
    end
  endtask

  task automatic test_pix_enable();
    obs_t prev [4];
    int   hs_low;
    logic e;
    hs_low = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3200; i++) begin
      for (int k = 0; k < 4; k++) prev[k] = act_of(k);
      e = ((i % 4) == 0);
      tick(1'b0, e);
      hs_low += (hs_a == 1'b0) ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (act_of(k) !== model(k, t)) begin
          bad++;
          $display("FAIL pix_enable inst=%0d t=%0d got=%h want=%h", k, t, act_of(k), model(k, t));
        end
        if (!e) begin
          total++;
          if (act_of(k) !== prev[k]) begin
            bad++;
            $display("FAIL hold inst=%0d got=%h want=%h", k, act_of(k), prev[k]);
          end
        end
      end
    end
    total++;
    if (hs_low != 384) begin
      bad++;
      $display("FAIL hsync_low_quarter_rate got=%0d want=384", hs_low);
    end
  endtask

  task automatic test_frames();
    int fs_cnt, ls_cnt, stray;
    logic [4:0] prev_hc, prev_vc;
    fs_cnt = 0;
    ls_cnt = 0;
    stray  = 0;
    tick(1'b1, 1'b1);
    prev_hc = hc_b;
    prev_vc = vc_b;
    for (int i = 0; i < 864; i++) begin
      tick(1'b0, 1'b1);
      fs_cnt += fs_b ? 1 : 0;
      ls_cnt += ls_b ? 1 : 0;
      if (vc_b != prev_vc && !(prev_hc == 5'd23 && hc_b == 5'd0)) stray++;
      prev_hc = hc_b;
      prev_vc = vc_b;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (act_of(k) !== model(k, t)) begin
          bad++;
          $display("FAIL frames inst=%0d t=%0d got=%h want=%h", k, t, act_of(k), model(k, t));
        end
      end
    end
    total++;
    if (fs_cnt != 2) begin
      bad++;
      $display("FAIL frame_start_count got=%0d want=2", fs_cnt);
    end
    total++;
    if (ls_cnt != 36) begin
      bad++;
      $display("FAIL line_start_count got=%0d want=36", ls_cnt);
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL v_advance_outside_wrap got=%0d want=0", stray);
    end
  endtask

  task automatic test_mid_reset();
    int stop;
    tick(1'b1, 1'b1);
    stop = 9 * 24 + 10 + $urandom_range(0, 5);
    while (t < stop) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);  // reset must win over a low pixEn
    total++;
    if ({hs_b, vs_b, vid_b, ls_b, fs_b, hc_b, vc_b} !== {5'b11000, 10'd0}) begin
      bad++;
      $display("FAIL mid_reset_pipe got=%b want=%b", {hs_b, vs_b, vid_b, ls_b, fs_b, hc_b, vc_b},
               {5'b11000, 10'd0});
    end
    total++;
    if ({hc_a, vc_a, fs_a} !== 21'd1) begin
      bad++;
      $display("FAIL mid_reset_origin got=%h want=1", {hc_a, vc_a, fs_a});
    end
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
        total++;
        if (act_of(k) !== model(k, t)) begin
          bad++;
          $display("FAIL after_reset inst=%0d t=%0d got=%h want=%h", k, t, act_of(k), model(k, t));
        end
      end
    end
  endtask

  task automatic test_pipe_align();
    obs_t hist [1024];
    tick(1'b1, 1'b1);
    hist[0] = act_of(2);
    for (int i = 0; i < 600; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)));
      hist[t] = act_of(2);
      if (t >= 3) begin
        total++;
        if (act_of(3) !== hist[t-3]) begin
          bad++;
          $display("FAIL pipe_align t=%0d got=%h want=%h", t, act_of(3), hist[t-3]);
        end
      end
      total++;
      if (act_of(3) !== model(3, t)) begin
        bad++;
        $display("FAIL pipe_model t=%0d got=%h want=%h", t, act_of(3), model(3, t));
      end
    end
  endtask

  task automatic test_polarity();
    int hs_hi, vs_hi, misplaced;
    hs_hi     = 0;
    vs_hi     = 0;
    misplaced = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 105; i++) begin
      tick(1'b0, 1'b1);
      hs_hi += hs_c ? 1 : 0;
      vs_hi += vs_c ? 1 : 0;
      if (hs_c && (hc_c < 4'd10 || hc_c > 4'd12)) misplaced++;
      if (vs_c && vc_c != 4'd5) misplaced++;
    end
    total++;
    if (hs_hi != 21) begin
      bad++;
      $display("FAIL hsync_high_per_frame got=%0d want=21", hs_hi);
    end
    total++;
    if (vs_hi != 15) begin
      bad++;
      $display("FAIL vsync_high_per_frame got=%0d want=15", vs_hi);
    end
    total++;
    if (misplaced != 0) begin
      bad++;
      $display("FAIL sync_position got=%0d want=0", misplaced);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pix_enable();
    test_frames();
    test_mid_reset();
    test_pipe_align();
    test_polarity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
